// File: rtl/rv32_pkg.sv
// Shared RV32I encoding constants and the request record handed from the
// encoder to the field packer.
package rv32_pkg;

    // Format codes, identical to the immediate extender's immsrc encoding.
    localparam logic [2:0] FMT_I = 3'b000;
    localparam logic [2:0] FMT_S = 3'b001;
    localparam logic [2:0] FMT_B = 3'b010;
    localparam logic [2:0] FMT_J = 3'b011;
    localparam logic [2:0] FMT_U = 3'b100;
    localparam logic [2:0] FMT_R = 3'b101;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } enc_req_t;

    // True when v is representable as a signed value of the given bit width.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
        logic [31:0] hi;
        hi = $unsigned($signed(v) >>> (bits - 1));
        return (hi == 32'h0) || (hi == 32'hFFFF_FFFF);
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational field packer: builds the RV32I word for one request and
// flags immediates the chosen format cannot represent.
module imm_pack
    import rv32_pkg::*;
(
    input  enc_req_t    req,
    output logic [31:0] instr,
    output logic        illegal
);

    always_comb begin
        instr   = NOP_INSTR;
        illegal = 1'b0;
        case (req.fmt)
            FMT_I: begin
                instr   = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
                illegal = !fits_signed(req.imm, 12);
            end
            FMT_S: begin
                instr   = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], req.opcode};
                illegal = !fits_signed(req.imm, 12);
            end
            FMT_B: begin
                instr   = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                           req.imm[4:1], req.imm[11], req.opcode};
                illegal = !fits_signed(req.imm, 13) || req.imm[0];
            end
            FMT_J: begin
                instr   = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12],
                           req.rd, req.opcode};
                illegal = !fits_signed(req.imm, 21) || req.imm[0];
            end
            FMT_U: begin
                instr   = {req.imm[31:12], req.rd, req.opcode};
                illegal = |req.imm[11:0];
            end
            FMT_R: begin
                instr   = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: registers packed RV32I words behind a valid/ready
// stage, stamping each with a sequential word address and an error flag.
module instr_encoder
    import rv32_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_fmt,
    input  logic [6:0]      in_opcode,
    input  logic [4:0]      in_rd,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [2:0]      in_funct3,
    input  logic [6:0]      in_funct7,
    input  logic [XLEN-1:0] in_imm,
    input  logic            addr_load,
    input  logic [XLEN-1:0] addr_val,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_addr,
    output logic            out_err,
    output logic [7:0]      err_count
);

    enc_req_t    req;
    logic [31:0] pack_instr;
    logic        pack_illegal;
    logic        accept;
    logic [31:0] load_addr;
    logic [31:0] beat_addr;
    logic        unused_addr_lsbs;

    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_addr_q,  out_addr_d;
    logic        out_err_q,   out_err_d;
    logic [7:0]  err_count_q, err_count_d;
    logic [31:0] next_addr_q, next_addr_d;

    assign req = '{fmt: in_fmt, opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                   funct3: in_funct3, funct7: in_funct7, imm: in_imm};

    imm_pack u_imm_pack (
        .req     (req),
        .instr   (pack_instr),
        .illegal (pack_illegal)
    );

    assign in_ready         = !reset && (!out_valid_q || out_ready);
    assign accept           = in_valid && in_ready;
    assign load_addr        = {addr_val[31:2], 2'b00};
    assign unused_addr_lsbs = ^addr_val[1:0];
    assign beat_addr        = addr_load ? load_addr : next_addr_q;

    always_comb begin
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_addr_d  = out_addr_q;
        out_err_d   = out_err_q;
        err_count_d = err_count_q;
        next_addr_d = next_addr_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_instr_d = pack_illegal ? NOP_INSTR : pack_instr;
            out_err_d   = pack_illegal;
            out_addr_d  = beat_addr;
            next_addr_d = beat_addr + 32'd4;
            if (pack_illegal && (err_count_q != 8'hFF))
                err_count_d = err_count_q + 8'd1;
        end else begin
            if (out_ready)
                out_valid_d = 1'b0;
            if (addr_load)
                next_addr_d = load_addr;
        end
    end

    // Reset also wins over addr_load, so next_addr always restarts at BASE_ADDR.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_instr_q <= 32'h0;
            out_addr_q  <= BASE_ADDR;
            out_err_q   <= 1'b0;
            err_count_q <= 8'h0;
            next_addr_q <= BASE_ADDR;
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_addr_q  <= out_addr_d;
            out_err_q   <= out_err_d;
            err_count_q <= err_count_d;
            next_addr_q <= next_addr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_addr  = out_addr_q;
    assign out_err   = out_err_q;
    assign err_count = err_count_q;

endmodule
